// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared defaults and stage-occupancy encoding for hs_pipe
package hs_pkg;

    localparam int HS_WIDTH_DEF = 8;
    localparam int HS_DEPTH_DEF = 2;
    localparam int HS_CNT_W_DEF = 3;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/hs_skid_stage.sv
// rtl/hs_skid_stage.sv - one pipeline stage: main register plus skid register
module hs_skid_stage
    import hs_pkg::*;
#(
    parameter int WIDTH = HS_WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             push, pop;

    // Ready depends only on our own skid slot, so out_ready never reaches in_ready.
    assign in_ready_o  = (occ_q != OCC_TWO);
    assign out_valid_o = (occ_q != OCC_EMPTY);
    assign out_data_o  = main_q;

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    main_d = in_data_i;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    main_d = in_data_i;
                end else if (push) begin
                    skid_d = in_data_i;
                    occ_d  = OCC_TWO;
                end else if (pop) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                // Skid is older than anything upstream, so it refills main first.
                if (pop) begin
                    main_d = skid_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q <= OCC_EMPTY;
        end else begin
            occ_q <= occ_d;
        end
        main_q <= main_d;
        skid_q <= skid_d;
    end

endmodule

// File: rtl/hs_pipe.sv
// rtl/hs_pipe.sv - DEPTH-stage valid/ready pipeline; HS_PIPE_STALL_CNT_EN adds stall_cnt
module hs_pipe
    import hs_pkg::*;
#(
    parameter int WIDTH = HS_WIDTH_DEF,
    parameter int DEPTH = HS_DEPTH_DEF,
    parameter int CNT_W = HS_CNT_W_DEF
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] result
`ifdef HS_PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    logic [DEPTH:0]            vld;
    logic [DEPTH:0]            rdy;
    logic [DEPTH:0][WIDTH-1:0] dat;
    logic                      out_xfer;
    logic [CNT_W-1:0]          result_q, result_d;

    assign vld[0]     = in_valid;
    assign dat[0]     = in_data;
    assign rdy[DEPTH] = out_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        hs_skid_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk_i       (sys_clk),
            .rst_i       (rst),
            .in_valid_i  (vld[g]),
            .in_data_i   (dat[g]),
            .in_ready_o  (rdy[g]),
            .out_valid_o (vld[g+1]),
            .out_data_o  (dat[g+1]),
            .out_ready_i (rdy[g+1])
        );
    end

    // Hold in_ready low while reset is applied, even though the stages read empty.
    assign in_ready  = rdy[0] && !rst;
    assign out_valid = vld[DEPTH];
    assign out_data  = dat[DEPTH];
    assign out_xfer  = out_valid && out_ready;

    assign result_d = result_q + {{(CNT_W-1){1'b0}}, out_xfer};
    assign result   = result_q;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

`ifdef HS_PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    assign stall_d   = stall_q + {{(CNT_W-1){1'b0}}, (out_valid && !out_ready)};
    assign stall_cnt = stall_q;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_hs_pipe.sv
// tb/tb_hs_pipe.sv - directed bench with output scoreboard for hs_pipe
module tb_hs_pipe;

    logic       sys_clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] result;
`ifdef HS_PIPE_STALL_CNT_EN
    logic [2:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    hs_pipe #(
        .WIDTH (8),
        .DEPTH (2),
        .CNT_W (3)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .result    (result)
`ifdef HS_PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Inputs are stable from posedge+1 to the next posedge, so the negedge
    // sees exactly what the coming edge will transfer.
    always @(negedge sys_clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) exp_q.push_back(in_data);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {24'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("scoreboard_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        tick();
        tick();
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result",    {29'd0, result},    32'd0);
        chk("reset_in_ready",  {31'd0, in_ready},  32'd0);
`ifdef HS_PIPE_STALL_CNT_EN
        chk("reset_stall_cnt", {29'd0, stall_cnt}, 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);

        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            tick();
            if (k == 1) begin
                chk("stream_latency_gap", {31'd0, out_valid}, 32'd0);
            end else begin
                chk("stream_valid", {31'd0, out_valid}, 32'd1);
                chk("stream_data",  {24'd0, out_data},  32'(k - 1));
            end
        end
        in_valid = 1'b0;
        tick();
        chk("stream_tail_valid", {31'd0, out_valid}, 32'd1);
        chk("stream_tail_data",  {24'd0, out_data},  32'h05);
        tick();
        chk("stream_drained", {31'd0, out_valid}, 32'd0);
        chk("stream_result",  {29'd0, result},    32'd5);

        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h10 + k);
            chk("fill_in_ready", {31'd0, in_ready}, (k < 4) ? 32'd1 : 32'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data",  {24'd0, out_data},  32'h10);
        out_ready = 1'b1;
        repeat (5) tick();
        chk("fill_drained", 32'(exp_q.size()), 32'd0);
        chk("wrap_result",  {29'd0, result},   32'd1);

        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h30 + k);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_result",    {29'd0, result},    32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);

        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        tick();
        in_valid  = 1'b0;
        chk("aa_gap", {31'd0, out_valid}, 32'd0);
        tick();
        chk("aa_valid", {31'd0, out_valid}, 32'd1);
        chk("aa_data",  {24'd0, out_data},  32'hAA);
        tick();
        chk("aa_alone",  {31'd0, out_valid}, 32'd0);
        chk("aa_result", {29'd0, result},    32'd1);

`ifdef HS_PIPE_STALL_CNT_EN
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        tick();
        in_valid  = 1'b0;
        tick();
        chk("stall_start", {29'd0, stall_cnt}, 32'd0);
        repeat (3) tick();
        chk("stall_cnt", {29'd0, stall_cnt}, 32'd3);
        out_ready = 1'b1;
        repeat (2) tick();
`endif

        chk("final_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hs_pipe.md
HS_PIPE -- requirements
Module: hs_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 2: number of pipeline stages; legal range 1..8.
REQ-003 SHALL have parameter CNT_W, default 3: width of the transfer counter.
REQ-004 SHALL have port sys_clk  input  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1: synchronous reset, active-high.
REQ-006 SHALL have port in_valid  input  1: upstream data valid.
REQ-007 SHALL have port in_data  input  WIDTH: upstream payload.
REQ-008 SHALL have port in_ready  output  1: block can accept this cycle.
REQ-009 SHALL have port out_valid  output  1: payload available downstream.
REQ-010 SHALL have port out_data  output  WIDTH: downstream payload.
REQ-011 SHALL have port out_ready  input  1: downstream accepts.
REQ-012 SHALL have port result  output  CNT_W: count of completed output transfers, modulo 2^CNT_W.
REQ-013 SHALL have port stall_cnt  output  CNT_W: present only when HS_PIPE_STALL_CNT_EN is defined.

Function
REQ-014 SHALL treat a transfer as occurring on a cycle where valid and ready are both 1 on the same interface; no other condition moves data.
REQ-015 SHALL be built as DEPTH chained stages, each holding up to 2 entries: main register and skid register.
REQ-016 SHALL drive each stage's upstream ready solely from its own skid-register occupancy (ready = skid empty); no combinational path from out_ready to in_ready.
REQ-017 SHALL give a latency of exactly DEPTH cycles from input transfer to out_valid=1 with out_ready held 1.
REQ-018 SHALL sustain one transfer per cycle when out_ready is held 1 (full throughput, no bubbles).
REQ-019 SHALL preserve order and values: the out_data sequence equals the accepted in_data sequence with no loss or duplication.
REQ-020 SHALL hold out_valid and out_data stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, on backpressure, fill the skid register when the main register is occupied and cannot drain; total capacity is 2*DEPTH entries.
REQ-022 SHALL drop in_ready to 0 once all 2*DEPTH entries are occupied and out_ready=0, and ignore in_valid while in_ready=0.
REQ-023 SHALL, on a stage with a simultaneous push and pop, pass skid data to main first (skid drains before new data enters main).
REQ-024 SHALL increment result by 1 on each output transfer; wrap from 2^CNT_W-1 to 0.
REQ-025 SHALL NOT change out_data in a way visible to a reader when out_valid=0; it is don't-care then.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, clear all stage occupancy; out_valid=0, result=0, stall_cnt=0, in_ready=0 during reset.
REQ-027 SHALL assert in_ready=1 on the first cycle after rst deasserts.
REQ-028 SHALL discard in-flight data on reset asserted mid-operation; nothing accepted before reset appears after it.

Configuration
REQ-029 SHALL, when HS_PIPE_STALL_CNT_EN is defined, include stall_cnt, incrementing (wrapping) on each cycle where out_valid=1 and out_ready=0.
REQ-030 SHALL, when HS_PIPE_STALL_CNT_EN is undefined, omit the stall_cnt port and its logic entirely; all other behaviour is identical.

Structure
REQ-031 SHALL place the default constants (WIDTH, DEPTH, CNT_W defaults) and the stage-occupancy encoding (EMPTY, ONE, TWO) in shared package hs_pkg.
REQ-032 SHALL implement one stage as sub-module hs_skid_stage (parameter WIDTH), instantiated DEPTH times by a generate loop.

Verification (WIDTH=8, DEPTH=2, CNT_W=3)
REQ-033 SHALL check reset: rst=1 for 2 cycles -> out_valid=0, result=0, in_ready=0; after release in_ready=1 next cycle.
REQ-034 SHALL check streaming: in_valid=1, out_ready=1, data 0x01..0x05 on consecutive cycles -> 0x01 appears 2 cycles after acceptance, then one item per cycle; result=5.
REQ-035 SHALL check backpressure fill: out_ready=0, push 0x10..0x14 -> 0x10..0x13 accepted, in_ready=0 after the 4th; release out_ready -> 0x10..0x13 in order.
REQ-036 SHALL check wrap: 9 output transfers -> result reads 1.
REQ-037 SHALL check mid-flight reset: 3 entries held, rst pulse -> out_valid=0; new item 0xAA emerges alone after 2 cycles.
REQ-038 SHALL check stall count with HS_PIPE_STALL_CNT_EN defined: out_valid=1 held with out_ready=0 for 3 cycles -> stall_cnt=3.
